// File: rtl/systolic_pkg.sv
// systolic_pkg: shared defaults, tag layout and lane slicing helpers for the systolic write-back path
package systolic_pkg;
  localparam int DEF_PE_COL = 16;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_AFIFO_DEPTH = 32;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  first;
  } psum_tag_t;
  function automatic int tag_width(input int aw);
    return aw + 1;
  endfunction
  function automatic int lane_lo(input int c, input int w);
    return c * w;
  endfunction
endpackage

// File: rtl/psum_tag_fifo.sv
// psum_tag_fifo: synchronous FIFO for row address/tag; an empty FIFO forwards din when push and pop coincide
module psum_tag_fifo #(
  parameter int DEPTH = 32,
  parameter int W = 18
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & (~full | pop);
  assign do_pop = pop & (~empty | push);
  assign dout = empty ? din : mem[rp];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/systolic_psum_writer.sv
// systolic_psum_writer: de-skews PE column results into rows and accumulates them into the global buffer
module systolic_psum_writer
  import systolic_pkg::*;
#(
  parameter int PE_COL = DEF_PE_COL,
  parameter int ACC_W = DEF_ACC_W,
  parameter int global_buf_addr_width = DEF_ADDR_W,
  parameter int AFIFO_DEPTH = DEF_AFIFO_DEPTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic                             write,
  input  logic [global_buf_addr_width-1:0] output_addr,
  input  logic                             first_partial,
  input  logic [PE_COL-1:0]                col_valid,
  input  logic [PE_COL*ACC_W-1:0]          col_data,
  output logic                             buf_rd_en,
  output logic [global_buf_addr_width-1:0] buf_rd_addr,
  input  logic [PE_COL*ACC_W-1:0]          buf_rd_data,
  output logic                             buf_wr_en,
  output logic [global_buf_addr_width-1:0] buf_wr_addr,
  output logic [PE_COL*ACC_W-1:0]          buf_wr_data,
  output logic                             idle,
  output logic                             err_overflow,
  output logic                             err_underflow,
  output logic                             err_skew
);
  localparam int AW = global_buf_addr_width;
  localparam int RW = PE_COL * ACC_W;
  localparam int TW = tag_width(AW);
  logic [PE_COL-1:0] al_v, lane_busy;
  logic [RW-1:0] al_d;
  logic row_v, have, skew_bad, fwd;
  logic fifo_full, fifo_empty;
  logic [TW-1:0] head;
  logic [$clog2(AFIFO_DEPTH):0] fifo_count;
  logic s1_v, s1_first, s2_v, s2_first, pv;
  logic [AW-1:0] s1_addr, s2_addr, pa;
  logic [RW-1:0] s1_row, s2_row, pd, base, sum;
  psum_tag_fifo #(.DEPTH(AFIFO_DEPTH), .W(TW)) u_fifo (
    .clk(clk),
    .rstn(rstn),
    .push(write),
    .pop(row_v),
    .din({output_addr, first_partial}),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  // lane c is delayed PE_COL-1-c cycles so all lanes line up with the last column
  for (genvar c = 0; c < PE_COL; c++) begin : g_lane
    localparam int D = PE_COL - 1 - c;
    if (D == 0) begin : g_pass
      assign al_v[c] = col_valid[c];
      assign al_d[lane_lo(c, ACC_W) +: ACC_W] = col_data[lane_lo(c, ACC_W) +: ACC_W];
      assign lane_busy[c] = 1'b0;
    end else begin : g_dly
      logic [D-1:0] v;
      logic [D-1:0][ACC_W-1:0] d;
      always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
          v <= '0;
          d <= '0;
        end else begin
          v[0] <= col_valid[c];
          d[0] <= col_data[lane_lo(c, ACC_W) +: ACC_W];
          for (int k = 1; k < D; k++) begin
            v[k] <= v[k-1];
            d[k] <= d[k-1];
          end
        end
      assign al_v[c] = v[D-1];
      assign al_d[lane_lo(c, ACC_W) +: ACC_W] = d[D-1];
      assign lane_busy[c] = |v;
    end
  end
  assign row_v = al_v[0];
  assign have = ~fifo_empty | write;
  assign skew_bad = row_v & (al_v != {PE_COL{1'b1}});
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s1_v <= 1'b0;
      s1_first <= 1'b0;
      s1_addr <= '0;
      s1_row <= '0;
      s2_v <= 1'b0;
      s2_first <= 1'b0;
      s2_addr <= '0;
      s2_row <= '0;
      pv <= 1'b0;
      pa <= '0;
      pd <= '0;
    end else begin
      s1_v <= row_v & have;
      if (row_v & have) begin
        s1_addr <= head[TW-1:1];
        s1_first <= head[0];
        s1_row <= al_d;
      end
      s2_v <= s1_v;
      s2_first <= s1_first;
      s2_addr <= s1_addr;
      s2_row <= s1_row;
      pv <= s2_v;
      pa <= s2_addr;
      pd <= sum;
    end
  // the read for a row issued one cycle behind a write to the same word returns stale data
  always_comb begin
    fwd = pv & s2_v & (pa == s2_addr);
    base = fwd ? pd : buf_rd_data;
    sum = '0;
    for (int c = 0; c < PE_COL; c++)
      sum[c*ACC_W +: ACC_W] = s2_first ? s2_row[c*ACC_W +: ACC_W]
                                       : base[c*ACC_W +: ACC_W] + s2_row[c*ACC_W +: ACC_W];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      err_skew <= 1'b0;
    end else if (start) begin
      err_overflow <= 1'b0;
      err_underflow <= 1'b0;
      err_skew <= 1'b0;
    end else begin
      err_overflow <= err_overflow | (write & fifo_full & ~row_v);
      err_underflow <= err_underflow | (row_v & ~have);
      err_skew <= err_skew | skew_bad;
    end
  assign buf_rd_en = s1_v & ~s1_first;
  assign buf_rd_addr = s1_addr;
  assign buf_wr_en = s2_v;
  assign buf_wr_addr = s2_addr;
  assign buf_wr_data = s2_v ? sum : '0;
  assign idle = (fifo_count == '0) & ~|lane_busy & ~s1_v & ~s2_v;
endmodule

// File: tb/tb_systolic_psum_writer.sv
// tb_systolic_psum_writer: scoreboard bench driving skewed rows against a behavioural global buffer
module tb_systolic_psum_writer;
  localparam int PE = 16;
  localparam int W = 32;
  localparam int AW = 17;
  localparam int RW = PE * W;
  typedef struct {
    int            t0;
    logic [AW-1:0] addr;
    logic          first;
    logic [RW-1:0] data;
    bit            has_w;
    bit            has_c;
    int            skew;
  } row_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0, start = 1'b0, write = 1'b0, first_partial = 1'b0;
  logic [AW-1:0] output_addr = '0;
  logic [PE-1:0] col_valid = '0;
  logic [RW-1:0] col_data = '0, buf_rd_data = '0;
  logic buf_rd_en, buf_wr_en, idle, err_overflow, err_underflow, err_skew;
  logic [AW-1:0] buf_rd_addr, buf_wr_addr;
  logic [RW-1:0] buf_wr_data;
  row_t sched[$];
  exp_t exp_wr[$], exp_rd[$];
  logic [RW-1:0] mem [64];
  logic [RW-1:0] ref_mem [64];
  int cyc = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  systolic_psum_writer dut (
    .clk(clk), .rstn(rstn), .start(start), .write(write), .output_addr(output_addr),
    .first_partial(first_partial), .col_valid(col_valid), .col_data(col_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .idle(idle), .err_overflow(err_overflow), .err_underflow(err_underflow), .err_skew(err_skew)
  );
  // global buffer: read returns the value held before a same-edge write
  always @(posedge clk) begin
    logic [RW-1:0] r;
    r = mem[buf_rd_addr[5:0]];
    if (buf_wr_en) mem[buf_wr_addr[5:0]] = buf_wr_data;
    if (buf_rd_en) buf_rd_data <= r;
  end
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (buf_rd_en) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected got addr=%h cyc=%0d exp none", buf_rd_addr, cyc);
        end else begin
          e = exp_rd.pop_front();
          if (buf_rd_addr !== e.addr || cyc !== e.cyc) begin
            errors++;
            $display("FAIL rd_access got addr=%h cyc=%0d exp addr=%h cyc=%0d", buf_rd_addr, cyc, e.addr, e.cyc);
          end
        end
      end
      if (buf_wr_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected got addr=%h cyc=%0d exp none", buf_wr_addr, cyc);
        end else begin
          e = exp_wr.pop_front();
          if (buf_wr_addr !== e.addr || buf_wr_data !== e.data || cyc !== e.cyc) begin
            errors++;
            $display("FAIL wr_row got addr=%h lane0=%h lane15=%h cyc=%0d exp addr=%h lane0=%h lane15=%h cyc=%0d",
                     buf_wr_addr, buf_wr_data[31:0], buf_wr_data[RW-1 -: W], cyc,
                     e.addr, e.data[31:0], e.data[RW-1 -: W], e.cyc);
          end
        end
      end
    end
  end
  function automatic logic [RW-1:0] ramp(input int b, input int s);
    logic [RW-1:0] r;
    for (int c = 0; c < PE; c++) r[c*W +: W] = 32'(b + c * s);
    return r;
  endfunction
  task automatic apply();
    row_t r;
    write = 1'b0;
    first_partial = 1'b0;
    output_addr = '0;
    col_valid = '0;
    col_data = '0;
    while (sched.size() > 0 && sched[0].t0 + PE + 2 < cyc) void'(sched.pop_front());
    foreach (sched[i]) begin
      r = sched[i];
      if (r.has_w && r.t0 == cyc) begin
        write = 1'b1;
        output_addr = r.addr;
        first_partial = r.first;
      end
      if (r.has_c)
        for (int c = 0; c < PE; c++)
          if (cyc == r.t0 + c + ((c == r.skew) ? 1 : 0)) begin
            col_valid[c] = 1'b1;
            col_data[c*W +: W] = r.data[c*W +: W];
          end
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      apply();
    end
  endtask
  task automatic add_row(input logic [AW-1:0] addr, input logic first, input logic [RW-1:0] data,
                         input bit hw, input bit hc, input int skew, input int off);
    row_t r;
    exp_t e;
    logic [RW-1:0] nv;
    r.t0 = cyc + 1 + off;
    r.addr = addr;
    r.first = first;
    r.data = data;
    r.has_w = hw;
    r.has_c = hc;
    r.skew = skew;
    sched.push_back(r);
    if (hw && hc) begin
      for (int c = 0; c < PE; c++)
        nv[c*W +: W] = first ? data[c*W +: W] : ref_mem[addr[5:0]][c*W +: W] + data[c*W +: W];
      ref_mem[addr[5:0]] = nv;
      e.addr = addr;
      e.data = nv;
      e.cyc = r.t0 + PE + 1;
      exp_wr.push_back(e);
      if (!first) begin
        e.cyc = r.t0 + PE;
        exp_rd.push_back(e);
      end
    end
  endtask
  task automatic preload(input logic [AW-1:0] addr, input logic [RW-1:0] v);
    mem[addr[5:0]] = v;
    ref_mem[addr[5:0]] = v;
  endtask
  task automatic drain(output bit ok);
    int n = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0 || idle !== 1'b1) && n < 200) begin
      step(1);
      n++;
    end
    ok = n < 200;
  endtask
  task automatic flush_tb();
    sched.delete();
    exp_wr.delete();
    exp_rd.delete();
  endtask
  task automatic test_reset();
    bit ok;
    rstn = 1'b0;
    step(3);
    checks++;
    if ({buf_rd_en, buf_wr_en, err_overflow, err_underflow, err_skew} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000", {buf_rd_en, buf_wr_en, err_overflow, err_underflow, err_skew});
    end
    checks++;
    if (idle !== 1'b1 || buf_wr_data !== '0 || buf_rd_addr !== '0 || buf_wr_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs got idle=%b rd_addr=%h wr_addr=%h exp idle=1 zeros", idle, buf_rd_addr, buf_wr_addr);
    end
    rstn = 1'b1;
    step(2);
    add_row(17'h30, 1'b0, ramp(9, 1), 1'b1, 1'b1, -1, 0);
    step(8);
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL midstream_busy got idle=%b exp 0", idle);
    end
    rstn = 1'b0;
    flush_tb();
    #1;
    checks++;
    if ({buf_rd_en, buf_wr_en, err_overflow, err_underflow, err_skew} !== 5'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstream got flags=%b idle=%b exp 00000 idle=1",
               {buf_rd_en, buf_wr_en, err_overflow, err_underflow, err_skew}, idle);
    end
    step(2);
    rstn = 1'b1;
    step(1);
    add_row(17'h18, 1'b1, ramp(3, 3), 1'b1, 1'b1, -1, 0);
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_recover_timeout got pending=%0d exp 0", exp_wr.size());
    end
    checks++;
    if (mem[6'h18] !== ramp(3, 3)) begin
      errors++;
      $display("FAIL reset_recover_data got lane0=%h exp %h", mem[6'h18][31:0], 32'd3);
    end
  endtask
  task automatic test_first_partial();
    bit ok;
    add_row(17'h10, 1'b1, ramp(1, 1), 1'b1, 1'b1, -1, 0);
    drain(ok);
    checks++;
    if (!ok || mem[6'h10] !== ramp(1, 1)) begin
      errors++;
      $display("FAIL first_partial got ok=%0d lane15=%h exp ok=1 lane15=%h", ok, mem[6'h10][RW-1 -: W], 32'd16);
    end
  endtask
  task automatic test_accumulate();
    bit ok;
    preload(17'h10, ramp(100, 0));
    add_row(17'h10, 1'b0, ramp(1, 1), 1'b1, 1'b1, -1, 0);
    drain(ok);
    checks++;
    if (!ok || mem[6'h10] !== ramp(101, 1)) begin
      errors++;
      $display("FAIL accumulate got ok=%0d lane0=%h lane15=%h exp lane0=%h lane15=%h",
               ok, mem[6'h10][31:0], mem[6'h10][RW-1 -: W], 32'd101, 32'd116);
    end
  endtask
  task automatic test_back_to_back();
    bit ok;
    preload(17'h20, '0);
    add_row(17'h20, 1'b0, ramp(5, 0), 1'b1, 1'b1, -1, 0);
    add_row(17'h20, 1'b0, ramp(7, 0), 1'b1, 1'b1, -1, 1);
    drain(ok);
    checks++;
    if (!ok || mem[6'h20] !== ramp(12, 0)) begin
      errors++;
      $display("FAIL back_to_back got ok=%0d lane0=%h exp %h", ok, mem[6'h20][31:0], 32'd12);
    end
  endtask
  task automatic test_wrap_overflow();
    bit ok;
    logic [RW-1:0] v, d;
    v = '0;
    v[31:0] = 32'h7FFF_FFFF;
    d = '0;
    d[31:0] = 32'd1;
    preload(17'h08, v);
    add_row(17'h08, 1'b0, d, 1'b1, 1'b1, -1, 0);
    drain(ok);
    checks++;
    if (!ok || mem[6'h08][31:0] !== 32'h8000_0000 || mem[6'h08][RW-1:32] !== '0) begin
      errors++;
      $display("FAIL wrap got ok=%0d lane0=%h exp %h", ok, mem[6'h08][31:0], 32'h8000_0000);
    end
    for (int i = 0; i < 33; i++) add_row(17'(i), 1'b0, '0, 1'b1, 1'b0, -1, i);
    step(33);
    checks++;
    if (err_overflow !== 1'b0 || idle !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_no_err got ovf=%b idle=%b exp ovf=0 idle=0", err_overflow, idle);
    end
    step(1);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got %b exp 1", err_overflow);
    end
    step(3);
    checks++;
    if (err_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got %b exp 1", err_overflow);
    end
    rstn = 1'b0;
    flush_tb();
    step(2);
    rstn = 1'b1;
    step(1);
    checks++;
    if (err_overflow !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL overflow_reset got ovf=%b idle=%b exp ovf=0 idle=1", err_overflow, idle);
    end
  endtask
  task automatic test_errors();
    bit ok;
    logic [RW-1:0] d;
    add_row(17'h3a, 1'b1, ramp(1, 1), 1'b0, 1'b1, -1, 0);
    step(PE + 4);
    checks++;
    if ({err_overflow, err_underflow, err_skew} !== 3'b010) begin
      errors++;
      $display("FAIL underflow got ovf/unf/skew=%b exp 010", {err_overflow, err_underflow, err_skew});
    end
    d = ramp(1, 1);
    d[3*W +: W] = '0;
    add_row(17'h38, 1'b1, d, 1'b1, 1'b1, 3, 0);
    drain(ok);
    checks++;
    if (!ok || {err_overflow, err_underflow, err_skew} !== 3'b011) begin
      errors++;
      $display("FAIL skew got ok=%0d ovf/unf/skew=%b exp 011", ok, {err_overflow, err_underflow, err_skew});
    end
    checks++;
    if (mem[6'h38] !== d) begin
      errors++;
      $display("FAIL skew_row_written got lane0=%h exp %h", mem[6'h38][31:0], 32'd1);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    checks++;
    if ({err_overflow, err_underflow, err_skew} !== 3'b000) begin
      errors++;
      $display("FAIL start_clear got %b exp 000", {err_overflow, err_underflow, err_skew});
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    test_reset();
    test_first_partial();
    test_accumulate();
    test_back_to_back();
    test_wrap_overflow();
    test_errors();
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got wr=%0d rd=%0d exp 0", exp_wr.size(), exp_rd.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got cyc=%0d exp finish", cyc);
    $fatal(1);
  end
endmodule
